// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round scheduler.
//   - FSM state encoding (raw constants plus the enum built from them)
//   - Display widths and saturation limits for score/level/lives
//   - calc_period(): tick period for a given difficulty level
package whack_pkg;

    localparam int SCORE_W = 8;
    localparam int LEVEL_W = 3;
    localparam int LIVES_W = 3;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

    // Raw encodings kept as plain constants so older code that compares
    // against bit patterns still lines up with the enum below.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_SHOW = 3'd2;
    localparam logic [2:0] ST_HIT  = 3'd3;
    localparam logic [2:0] ST_MISS = 3'd4;
    localparam logic [2:0] ST_OVER = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        SHOW = ST_SHOW,
        HIT  = ST_HIT,
        MISS = ST_MISS,
        OVER = ST_OVER
    } state_t;

    // Period = max(base - level*step, min_p). The product is formed wide
    // and compared against the headroom (base - min_p) before any
    // subtraction, so the result can never wrap below the floor.
    function automatic logic [31:0] calc_period(
        input logic [31:0]        base,
        input logic [31:0]        step,
        input logic [31:0]        min_p,
        input logic [LEVEL_W-1:0] level
    );
        logic [34:0] dec;
        dec = 35'(level) * 35'(step);
        if (base <= min_p)
            calc_period = min_p;
        else if (dec >= 35'(base - min_p))
            calc_period = min_p;
        else
            calc_period = base - dec[31:0];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable down-counter producing the game-pace tick.
// Ports:
//   ClockIn - system clock
//   Reset   - synchronous, active-high
//   Hold    - keep the counter parked at Period-1 and suppress Tick
//   Period  - cycles per tick; sampled only when the counter reloads
//   Tick    - one-cycle pulse while the count sits at zero
module tick_divider (
    input  logic        ClockIn,
    input  logic        Reset,
    input  logic        Hold,
    input  logic [31:0] Period,
    output logic        Tick
);

    logic [31:0] r_count;
    logic [31:0] w_load;

    assign w_load = Period - 32'd1;

    // Period is only looked at on a load, so a level change never
    // disturbs a count already in flight.
    always_ff @(posedge ClockIn) begin
        if (Reset || Hold || (r_count == 32'd0))
            r_count <= w_load;
        else
            r_count <= r_count - 32'd1;
    end

    assign Tick = !Hold && (r_count == 32'd0);

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole game sequencer: paces rounds with a tick divider, picks a
// pseudo-random hole each round, waits for a hit or a tick-based timeout
// and keeps score, lives and difficulty level.
// Ports:
//   ClockIn  - system clock
//   Reset    - synchronous, active-high
//   Start    - one-cycle pulse, starts/restarts a game from IDLE or OVER
//   Hit      - one-cycle debounced button pulses, one bit per hole
//   MoleMask - one-hot raised mole, zero when none is up
//   Score    - hits this game, saturating
//   Lives    - remaining lives
//   Level    - difficulty level, saturating at LEVEL_MAX
//   Tick     - divider pulse
//   GameOver - high while the game is over
module mole_round_scheduler
    import whack_pkg::*;
#(
    parameter int          NUM_HOLES      = 4,
    parameter int unsigned BASE_PERIOD    = 50000000,
    parameter int unsigned PERIOD_STEP    = 5000000,
    parameter int unsigned MIN_PERIOD     = 10000000,
    parameter int          SHOW_TICKS     = 2,
    parameter int          START_LIVES    = 3,
    parameter int          HITS_PER_LEVEL = 5,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 ClockIn,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [NUM_HOLES-1:0] Hit,
    output logic [NUM_HOLES-1:0] MoleMask,
    output logic [SCORE_W-1:0]   Score,
    output logic [LIVES_W-1:0]   Lives,
    output logic [LEVEL_W-1:0]   Level,
    output logic                 Tick,
    output logic                 GameOver
);

    localparam int HOLE_W   = $clog2(NUM_HOLES);
    localparam int TIMER_W  = $clog2(SHOW_TICKS + 1);
    localparam int HITCNT_W = $clog2(HITS_PER_LEVEL + 1);

    state_t                r_state;
    logic [NUM_HOLES-1:0]  r_mask;
    logic [SCORE_W-1:0]    r_score;
    logic [LIVES_W-1:0]    r_lives;
    logic [LEVEL_W-1:0]    r_level;
    logic [HITCNT_W-1:0]   r_hitcnt;
    logic [15:0]           r_lfsr;
    logic [HOLE_W-1:0]     r_prev_hole;
    logic [TIMER_W-1:0]    r_timer;

    logic                  w_hold;
    logic [31:0]           w_div_period;
    logic                  w_tick;
    logic [15:0]           w_lfsr_next;
    logic [HOLE_W-1:0]     w_hole_raw;
    logic [HOLE_W-1:0]     w_hole;
    logic [NUM_HOLES-1:0]  w_hole_onehot;
    logic                  w_hit_mole;

    // ------------------------------------------------------------------
    // Divider. While parked (IDLE/OVER) it is preloaded with the level-0
    // period, so the first round of a new game runs at base pace even if
    // the previous game left Level high.
    // ------------------------------------------------------------------
    assign w_hold = (r_state == IDLE) || (r_state == OVER);
    assign w_div_period = w_hold
        ? calc_period(32'(BASE_PERIOD), 32'(PERIOD_STEP), 32'(MIN_PERIOD), '0)
        : calc_period(32'(BASE_PERIOD), 32'(PERIOD_STEP), 32'(MIN_PERIOD), r_level);

    tick_divider u_tick_divider (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .Hold    (w_hold),
        .Period  (w_div_period),
        .Tick    (w_tick)
    );

    // ------------------------------------------------------------------
    // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    // ------------------------------------------------------------------
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

    // Hole selection: bump by one (wrapping, NUM_HOLES is a power of 2)
    // whenever the LFSR repeats the previous hole.
    assign w_hole_raw = r_lfsr[HOLE_W-1:0];
    assign w_hole     = (w_hole_raw == r_prev_hole) ? (w_hole_raw + HOLE_W'(1)) : w_hole_raw;

    generate
        for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole_dec
            assign w_hole_onehot[gi] = (w_hole == HOLE_W'(gi));
        end
    endgenerate

    assign w_hit_mole = |(Hit & r_mask);

    // ------------------------------------------------------------------
    // Game FSM and counters.
    // ------------------------------------------------------------------
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_score     <= '0;
            r_lives     <= LIVES_W'(START_LIVES);
            r_level     <= '0;
            r_hitcnt    <= '0;
            r_lfsr      <= LFSR_SEED;
            r_prev_hole <= '0;
            r_timer     <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                IDLE, OVER: begin
                    if (Start) begin
                        r_score  <= '0;
                        r_level  <= '0;
                        r_hitcnt <= '0;
                        r_lives  <= LIVES_W'(START_LIVES);
                        r_mask   <= '0;
                        r_state  <= ARM;
                    end
                end
                ARM: begin
                    if (w_tick) begin
                        r_mask      <= w_hole_onehot;
                        r_prev_hole <= w_hole;
                        r_timer     <= TIMER_W'(SHOW_TICKS);
                        r_state     <= SHOW;
                    end
                end
                SHOW: begin
                    // A correct press beats a coincident timeout tick.
                    if (w_hit_mole) begin
                        r_mask  <= '0;
                        r_state <= HIT;
                    end else if (w_tick) begin
                        r_timer <= r_timer - TIMER_W'(1);
                        if (r_timer == TIMER_W'(1)) begin
                            r_mask  <= '0;
                            r_state <= MISS;
                        end
                    end
                end
                HIT: begin
                    if (r_score != SCORE_MAX)
                        r_score <= r_score + SCORE_W'(1);
                    if (r_hitcnt == HITCNT_W'(HITS_PER_LEVEL - 1)) begin
                        r_hitcnt <= '0;
                        if (r_level != LEVEL_MAX)
                            r_level <= r_level + LEVEL_W'(1);
                    end else begin
                        r_hitcnt <= r_hitcnt + HITCNT_W'(1);
                    end
                    r_state <= ARM;
                end
                MISS: begin
                    r_lives <= r_lives - LIVES_W'(1);
                    r_state <= (r_lives == LIVES_W'(1)) ? OVER : ARM;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MoleMask = r_mask;
    assign Score    = r_score;
    assign Lives    = r_lives;
    assign Level    = r_level;
    assign Tick     = w_tick;
    assign GameOver = (r_state == OVER);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Self-checking bench for mole_round_scheduler with a shortened pace
// (BASE 10, STEP 2, MIN 4, two hits per level, three lives).
module tb_mole_round_scheduler;

    localparam int NH = 4;

    localparam int K_HIT   = 0;  // correct press 3 cycles after the mole rises
    localparam int K_WRONG = 1;  // wrong-hole press, then a correct one
    localparam int K_LATE  = 2;  // correct press in the timeout tick cycle
    localparam int K_MISS  = 3;  // no press at all

    typedef struct {
        int kind;
        int exp_score;
        int exp_level;
        int exp_lives;
    } vec_t;

    typedef struct {
        int score;
        int level;
        int lives;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NH-1:0] hit = '0;
    logic [NH-1:0] mask;
    logic [7:0]    score;
    logic [2:0]    lives;
    logic [2:0]    level;
    logic          tick;
    logic          gameover;

    mole_round_scheduler #(
        .NUM_HOLES      (4),
        .BASE_PERIOD    (10),
        .PERIOD_STEP    (2),
        .MIN_PERIOD     (4),
        .SHOW_TICKS     (2),
        .START_LIVES    (3),
        .HITS_PER_LEVEL (2),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .ClockIn  (clk),
        .Reset    (rst),
        .Start    (start),
        .Hit      (hit),
        .MoleMask (mask),
        .Score    (score),
        .Lives    (lives),
        .Level    (level),
        .Tick     (tick),
        .GameOver (gameover)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   tick_total = 0;
    bit   rec_en   = 1'b0;
    int   tick_q[$];
    exp_t sb_q[$];
    int   prev_hole = 0;
    int   cur_score = 0;
    int   cur_level = 0;
    int   cur_lives = 3;

    vec_t va[17];
    vec_t vb[4];
    int   exp_iv[5];

    // Tick monitor: records the cycle number of every observed tick.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (tick) begin
                tick_total++;
                if (rec_en) tick_q.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int s, input int l, input int v);
        exp_t e;
        e.score = s;
        e.level = l;
        e.lives = v;
        sb_q.push_back(e);
    endtask

    task automatic compare_exp(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, nothing to compare", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_score"}, int'(score), e.score);
            check({name, "_level"}, int'(level), e.level);
            check({name, "_lives"}, int'(lives), e.lives);
        end
    endtask

    // Pulse Hit for one cycle; outputs settle two cycles after the pulse.
    task automatic press(input logic [NH-1:0] p, input int s, input int l,
                         input int v, input string name);
        hit = p;
        push_exp(s, l, v);
        step();
        hit = '0;
        step();
        compare_exp(name);
    endtask

    task automatic wait_mole(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (mask != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("mole_rise", int'(ok), 1);
    endtask

    task automatic check_outputs(input string name, input int m, input int s,
                                 input int lv, input int li, input int go, input int tk);
        check({name, "_mask"},     int'(mask),     m);
        check({name, "_score"},    int'(score),    s);
        check({name, "_level"},    int'(level),    lv);
        check({name, "_lives"},    int'(lives),    li);
        check({name, "_gameover"}, int'(gameover), go);
        check({name, "_tick"},     int'(tick),     tk);
    endtask

    task automatic start_game(input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        cur_score = 0;
        cur_level = 0;
        cur_lives = 3;
        check({name, "_gameover"}, int'(gameover), 0);
        check({name, "_score"},    int'(score),    0);
        check({name, "_lives"},    int'(lives),    3);
        check({name, "_level"},    int'(level),    0);
    endtask

    task automatic run_row(input vec_t v, input int idx);
        bit            ok;
        logic [NH-1:0] m;
        int            hole;
        int            nt;
        wait_mole(ok);
        if (!ok) return;
        m = mask;
        hole = 0;
        for (int b = 0; b < NH; b++) if (m[b]) hole = b;
        check("mole_onehot", int'($onehot(m)), 1);
        check("mole_new_hole", int'(hole != prev_hole), 1);
        prev_hole = hole;
        case (v.kind)
            K_HIT: begin
                repeat (3) step();
                press(m, v.exp_score, v.exp_level, v.exp_lives, "hit");
            end
            K_WRONG: begin
                repeat (2) step();
                press(~m, cur_score, cur_level, cur_lives, "wrong_hole");
                check("wrong_mask_kept", int'(mask), int'(m));
                press(m, v.exp_score, v.exp_level, v.exp_lives, "hit_after_wrong");
            end
            K_LATE: begin
                nt = 0;
                for (int i = 0; i < 200 && nt < 2; i++) begin
                    step();
                    if (tick) nt++;
                end
                check("late_ticks_seen", nt, 2);
                press(m, v.exp_score, v.exp_level, v.exp_lives, "hit_on_timeout");
            end
            default: begin
                nt = 0;
                ok = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    step();
                    if (mask == '0) begin
                        ok = 1'b1;
                        break;
                    end
                    if (tick) nt++;
                end
                check("miss_clear", int'(ok), 1);
                check("miss_ticks_up", nt, 2);
                push_exp(v.exp_score, v.exp_level, v.exp_lives);
                step();
                step();
                compare_exp("miss");
                check("miss_gameover", int'(gameover), int'(v.exp_lives == 0));
            end
        endcase
        cur_score = v.exp_score;
        cur_level = v.exp_level;
        cur_lives = v.exp_lives;
        $display("row %0d kind=%0d hole=%0d score=%0d level=%0d lives=%0d",
                 idx, v.kind, hole, score, level, lives);
    endtask

    initial begin
        int  t0;
        int  t1;
        int  t2;
        bit  ok;

        // ---------------- stimulus tables ----------------
        va[0] = '{K_HIT,   1, 0, 3};
        va[1] = '{K_HIT,   2, 1, 3};
        va[2] = '{K_HIT,   3, 1, 3};
        va[3] = '{K_HIT,   4, 2, 3};
        va[4] = '{K_WRONG, 5, 2, 3};
        va[5] = '{K_LATE,  6, 3, 3};
        va[6] = '{K_MISS,  6, 3, 2};
        for (int i = 7; i < 17; i++) begin
            va[i].kind      = K_HIT;
            va[i].exp_score = i;
            va[i].exp_level = (i / 2 > 7) ? 7 : i / 2;
            va[i].exp_lives = 2;
        end
        vb[0] = '{K_HIT,  1, 0, 3};
        vb[1] = '{K_MISS, 1, 0, 2};
        vb[2] = '{K_MISS, 1, 0, 1};
        vb[3] = '{K_MISS, 1, 0, 0};
        exp_iv = '{10, 10, 8, 8, 6};

        // ---------------- reset and idle ----------------
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check_outputs("reset", 0, 0, 0, 3, 0, 0);
        t0 = tick_total;
        repeat (50) step();
        check("idle_no_tick", tick_total - t0, 0);
        check_outputs("idle", 0, 0, 0, 3, 0, 0);
        $display("idle done: ticks=%0d", tick_total - t0);

        // ---------------- game A: hits, levels, corner cases ----------------
        rec_en = 1'b1;
        start_game("start_a");
        for (int i = 0; i < 17; i++) run_row(va[i], i);
        rec_en = 1'b0;
        check("tick_q_size", int'(tick_q.size() >= 6), 1);
        if (tick_q.size() >= 6)
            for (int i = 0; i < 5; i++)
                check($sformatf("tick_interval_%0d", i), tick_q[i+1] - tick_q[i], exp_iv[i]);

        // Level stays at 7 and the period stays clamped at the floor.
        check("level_sat", int'(level), 7);
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 100 && t2 < 0; i++) begin
            step();
            if (tick) begin
                if (t1 < 0) t1 = i;
                else t2 = i;
            end
        end
        check("clamped_period", t2 - t1, 4);
        $display("clamp: interval=%0d level=%0d", t2 - t1, level);

        // ---------------- reset in the middle of SHOW ----------------
        wait_mole(ok);
        step();
        rst = 1'b1;
        step();
        check_outputs("midshow_reset", 0, 0, 0, 3, 0, 0);
        rst = 1'b0;
        prev_hole = 0;
        t0 = tick_total;
        repeat (20) step();
        check("post_reset_no_tick", tick_total - t0, 0);
        $display("mid-SHOW reset: score=%0d lives=%0d", score, lives);

        // ---------------- game B: run out of lives ----------------
        start_game("start_b");
        for (int i = 0; i < 4; i++) run_row(vb[i], 100 + i);
        t0 = tick_total;
        repeat (30) step();
        check("over_no_tick", tick_total - t0, 0);
        check_outputs("over_hold", 0, 1, 0, 0, 1, 0);
        $display("game over: score=%0d lives=%0d", score, lives);

        // ---------------- restart from OVER ----------------
        start_game("restart");
        wait_mole(ok);
        $display("restart: mole=%0d score=%0d lives=%0d", mask, score, lives);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
